weight2_update: RTL and testbench
=================================

# weight2_update

Read-modify-write stage directly downstream of the output-layer delta generator. After a start pulse it consumes NHIDDEN consecutive signed weight deltas plus one bias delta for a single output neuron. It adds each delta, with saturation, to the stored value in the layer-2 weight/bias RAM. It then signals completion so the training sequencer can select the next neuron.

## Interface
- NWBITS, 16, weight/delta width (signed, Q2.13-style fixed point)
- NHIDDEN, 256, hidden neurons (weights per output neuron)
- NOUT, 10, output neurons
- COUNT_BIT2, 8, hidden counter width; NHIDDEN ≤ 2^COUNT_BIT2
- OBITS, 4, neuron index width
- ABITS, 12, RAM address width; 2^ABITS ≥ NOUT*NHIDDEN+NOUT
- clk  in  1  clock
- reset_b  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, same cycle the delta generator samples start_pos/start_neg
- neuron_idx  in  OBITS  output neuron being updated, sampled with start
- delta_weight  in  NWBITS  signed delta stream, one value per cycle
- delta_bias  in  NWBITS  signed bias delta, valid the cycle after start only
- rd_en  out  1  RAM read enable
- rd_addr  out  ABITS  RAM read address; synchronous RAM, 1-cycle read latency
- rd_data  in  NWBITS  RAM read data
- wr_en  out  1  RAM write enable
- wr_addr  out  ABITS  RAM write address
- wr_data  out  NWBITS  RAM write data
- busy  out  1  update in progress
- done  out  1  one-cycle pulse, update complete

## Operation
- RAM map: weight (n,j) at n*NHIDDEN+j; bias n at NOUT*NHIDDEN+n.
- States:
  - IDLE: start=1 → latch neuron_idx into base, cnt←0, go to RUN.
  - RUN: rd_en=1, rd_addr=base*NHIDDEN+cnt. Register delta_weight into d_q and the address into a_q. On cnt==NHIDDEN-1 go to BIAS; otherwise cnt+1.
  - BIAS: rd_en=1, rd_addr=NOUT*NHIDDEN+base. Use the bias delta captured in the first RUN cycle. Go to DRAIN.
  - DRAIN: 2 cycles, then IDLE.
- Write stage, registered: when a read issued in the previous cycle returns, wr_data←sat(rd_data+d_q), wr_addr←a_q (delayed), wr_en←1. Otherwise wr_en←0.
- Saturation: the (NWBITS+1)-bit sum is clamped to [-2^(NWBITS-1), 2^(NWBITS-1)-1]. Delta sign is already applied upstream; this block always adds.
- start while busy=1 is ignored; no queueing.
- neuron_idx ≥ NOUT: the update still runs. The addresses are computed as given, and keeping them legal is the sequencer's responsibility.
- Reset (including mid-update): state IDLE, cnt 0, all outputs 0. In-flight writes are dropped; RAM contents already written stay as written.

## Timing
- Start sampled at edge k.
- delta j is valid in cycle k+1+j; its read is issued in the same cycle.
- rd_data returns in cycle k+2+j; the write is visible in cycle k+3+j.
- Last weight write is visible in cycle k+NHIDDEN+2. Bias read is in cycle k+NHIDDEN+1; bias write is visible in cycle k+NHIDDEN+3.
- done=1 in cycle k+NHIDDEN+3, coincident with the bias write. busy=1 in cycles k+1 .. k+NHIDDEN+3.
- A new start is accepted at the edge ending the done cycle.
- At most one write per cycle. Read and write addresses never coincide within one update, so there is no RAW hazard.

## Structure
- Shared package: state encoding (IDLE/RUN/BIAS/DRAIN), the RAM map base constant NOUT*NHIDDEN, and the saturating-add function for sum width NWBITS+1.
- One sub-module, sat_add2: combinational NWBITS saturating adder. It is reused by the layer-1 updater.
- Datapath: a two-deep shift of {valid, addr, delta}, aligned with RAM latency.

## Test plan
- Neuron 3, all deltas +2, RAM zero-initialised. Required: weights 768..1023 = 2, bias at 2563 = delta_bias, done in cycle k+259, 257 total wr_en cycles.
- Weight = 32760, delta = +100 → 32767. Weight = -32760, delta = -100 → -32768.
- Delta stream = j-dependent ramp (j-128), neuron 0, RAM preloaded with 1000. Required: weight j = 872+j at address j, strictly in address order.
- start reasserted at cycles k+5 and k+200 → ignored; exactly one done pulse; the RAM image matches a single update.
- reset_b low at cycle k+100 for 2 cycles. Required: wr_en, busy and done drop to 0 immediately; addresses 0..96 are updated and the rest unchanged. The next start runs a full update normally.
- Back-to-back starts for neurons 9 then 0, the second at the edge ending the done cycle. Required: both neuron images are correct, and bias addresses are 2569 and 2560.

Source files
------------

// File: rtl/weight2_update_pkg.sv
// Shared definitions for the layer-2 weight/bias read-modify-write stage:
// default geometry, FSM state encoding, RAM map base and the saturating clamp.
package weight2_update_pkg;

    localparam int W2_NWBITS     = 16;
    localparam int W2_NHIDDEN    = 256;
    localparam int W2_NOUT       = 10;
    localparam int W2_COUNT_BIT2 = 8;
    localparam int W2_OBITS      = 4;
    localparam int W2_ABITS      = 12;

    // Biases live directly after the NOUT*NHIDDEN weight block.
    localparam int W2_BIAS_BASE  = W2_NOUT * W2_NHIDDEN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BIAS,
        ST_DRAIN
    } w2_state_t;

    // Clamp a sign-extended (nwbits+1)-bit sum into the signed nwbits range.
    function automatic logic signed [31:0] sat_sum(input logic signed [31:0] sum,
                                                   input int nwbits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (nwbits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (nwbits - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/weight2_update_sat_add2.sv
// Combinational NWBITS-wide saturating adder, shared with the layer-1 updater.
module sat_add2
    import weight2_update_pkg::*;
#(
    parameter int NWBITS = W2_NWBITS
) (
    input  logic signed [NWBITS-1:0] a,
    input  logic signed [NWBITS-1:0] b,
    output logic signed [NWBITS-1:0] sum
);

    logic signed [NWBITS:0] wide;

    always_comb begin
        wide = (NWBITS+1)'(a) + (NWBITS+1)'(b);
        sum  = NWBITS'(sat_sum(32'(wide), NWBITS));
    end

endmodule

// File: rtl/weight2_update.sv
// Layer-2 weight/bias updater: streams NHIDDEN weight deltas plus one bias delta
// for a single output neuron through a saturating read-modify-write on the RAM.
module weight2_update
    import weight2_update_pkg::*;
#(
    parameter int NWBITS     = W2_NWBITS,
    parameter int NHIDDEN    = W2_NHIDDEN,
    parameter int NOUT       = W2_NOUT,
    parameter int COUNT_BIT2 = W2_COUNT_BIT2,
    parameter int OBITS      = W2_OBITS,
    parameter int ABITS      = W2_ABITS
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     start,
    input  logic [OBITS-1:0]         neuron_idx,
    input  logic signed [NWBITS-1:0] delta_weight,
    input  logic signed [NWBITS-1:0] delta_bias,
    output logic                     rd_en,
    output logic [ABITS-1:0]         rd_addr,
    input  logic signed [NWBITS-1:0] rd_data,
    output logic                     wr_en,
    output logic [ABITS-1:0]         wr_addr,
    output logic signed [NWBITS-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [COUNT_BIT2-1:0] CNT_LAST  = COUNT_BIT2'(NHIDDEN - 1);
    localparam logic [COUNT_BIT2-1:0] CNT_ONE   = COUNT_BIT2'(1);
    localparam logic [ABITS-1:0]      BIAS_BASE = ABITS'(NOUT * NHIDDEN);

    w2_state_t               state;
    logic [COUNT_BIT2-1:0]   cnt;
    logic [OBITS-1:0]        base;
    logic                    drain_last;
    logic                    accept;

    logic                    vld_p1;
    logic [ABITS-1:0]        addr_p1;
    logic signed [NWBITS-1:0] delta_p1;
    logic signed [NWBITS-1:0] bias_q;
    logic signed [NWBITS-1:0] sum_p1;

    function automatic logic [ABITS-1:0] weight_addr(input logic [OBITS-1:0]      n,
                                                     input logic [COUNT_BIT2-1:0] j);
        return ABITS'(n) * ABITS'(NHIDDEN) + ABITS'(j);
    endfunction

    // A new update may also launch on the edge that ends the done cycle.
    always_comb begin
        accept = start && ((state == ST_IDLE) || (state == ST_DRAIN && drain_last));
    end

    // p0: read issue -- the FSM drives rd_en/rd_addr one cycle per delta.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            base       <= '0;
            drain_last <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state      <= ST_RUN;
                base       <= neuron_idx;
                cnt        <= '0;
                drain_last <= 1'b0;
                rd_en      <= 1'b1;
                rd_addr    <= weight_addr(neuron_idx, '0);
                busy       <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_RUN: begin
                        if (cnt == CNT_LAST) begin
                            state   <= ST_BIAS;
                            rd_addr <= BIAS_BASE + ABITS'(base);
                        end else begin
                            cnt     <= cnt + CNT_ONE;
                            rd_addr <= weight_addr(base, cnt + CNT_ONE);
                        end
                    end
                    ST_BIAS: begin
                        state      <= ST_DRAIN;
                        rd_en      <= 1'b0;
                        drain_last <= 1'b0;
                    end
                    ST_DRAIN: begin
                        if (!drain_last) begin
                            drain_last <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            drain_last <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // p1: align address and delta with the one-cycle RAM read latency.
    always_ff @(posedge clk) begin
        addr_p1  <= rd_addr;
        delta_p1 <= (state == ST_BIAS) ? bias_q : delta_weight;
        if (state == ST_RUN && cnt == '0) begin
            bias_q <= delta_bias;
        end
    end

    sat_add2 #(
        .NWBITS (NWBITS)
    ) u_sat_add2 (
        .a   (rd_data),
        .b   (delta_p1),
        .sum (sum_p1)
    );

    // p2: registered write-back; a reset drops anything still in flight.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vld_p1  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            vld_p1 <= rd_en;
            wr_en  <= vld_p1;
            if (vld_p1) begin
                wr_addr <= addr_p1;
                wr_data <= sum_p1;
            end
        end
    end

endmodule

// File: tb/tb_weight2_update.sv
// Bench for weight2_update: behavioural RAM, cycle schedule model and RAM image model.
module tb_weight2_update;

    localparam int NH    = 256;
    localparam int BIAS0 = 2560;
    localparam int SCHED = 8192;

    logic               clk          = 1'b0;
    logic               reset_b      = 1'b0;
    logic               start        = 1'b0;
    logic [3:0]         neuron_idx   = '0;
    logic signed [15:0] delta_weight = '0;
    logic signed [15:0] delta_bias   = '0;
    logic               rd_en;
    logic [11:0]        rd_addr;
    logic signed [15:0] rd_data      = '0;
    logic               wr_en;
    logic [11:0]        wr_addr;
    logic signed [15:0] wr_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    weight2_update dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .neuron_idx   (neuron_idx),
        .delta_weight (delta_weight),
        .delta_bias   (delta_bias),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    // Synchronous RAM with 1-cycle read latency plus a bench-side bulk preload port.
    logic signed [15:0] ram       [0:4095] = '{default: '0};
    logic signed [15:0] load_val  [0:4095];
    bit                 load_mask [0:4095];
    bit                 load_go = 1'b0;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
        if (wr_en) ram[wr_addr] <= wr_data;
        if (load_go) begin
            for (int a = 0; a < 4096; a++) begin
                if (load_mask[a]) ram[a] <= load_val[a];
            end
        end
    end

    typedef struct {
        bit busy;
        bit done;
        bit ren;
        int raddr;
        bit wen;
        int waddr;
        int wdata;
    } exp_t;

    exp_t sched   [0:SCHED-1];
    int   exp_mem [0:4095];
    int   dlt     [0:NH-1];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    int   done_seen = 0;
    int   last_done_cyc = -1;
    int   order_bad = 0;
    int   prev_waddr = -1;
    int   bias_log [$];

    function automatic int sat16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic compare_cycle();
        exp_t e;
        e = sched[cyc];
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
        check("rd_en", int'(rd_en), int'(e.ren));
        check("wr_en", int'(wr_en), int'(e.wen));
        if (e.ren) check("rd_addr", int'(rd_addr), e.raddr);
        if (e.wen) begin
            check("wr_addr", int'(wr_addr), e.waddr);
            check("wr_data", int'(wr_data), e.wdata);
        end
        if (wr_en) begin
            wr_seen++;
            if (int'(wr_addr) < BIAS0) begin
                if (int'(wr_addr) <= prev_waddr) order_bad++;
                prev_waddr = int'(wr_addr);
            end else begin
                bias_log.push_back(int'(wr_addr));
            end
        end
        if (done) begin
            done_seen++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic tick();
        if (cyc >= SCHED - 300) begin
            $display("FAIL cycle_budget: cycle %0d exceeds limit %0d", cyc, SCHED - 300);
            $fatal(1);
        end
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input int a, input int v);
        load_val[a]  = 16'(v);
        load_mask[a] = 1'b1;
        exp_mem[a]   = v;
    endtask

    task automatic commit_load();
        load_go = 1'b1;
        tick();
        load_go = 1'b0;
        for (int a = 0; a < 4096; a++) load_mask[a] = 1'b0;
    endtask

    task automatic check_image(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int a = 0; a < 4096; a++) begin
            if (int'(ram[a]) != exp_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d RAM words differ, first at %0d: got %0d, required %0d",
                     name, bad, first, int'(ram[first]), exp_mem[first]);
        end
    endtask

    // mode 0: plain update; 1: spurious starts at k+5 and k+200; 2: reset low at k+100 for 2 cycles.
    task automatic run_update(input int n, input int b, input int mode, output int k);
        int base;
        int nw;
        int last_busy;
        int v;
        k         = cyc;
        base      = n * NH;
        nw        = (mode == 2) ? 97 : NH;
        last_busy = (mode == 2) ? k + 99 : k + 259;
        for (int c = k + 1; c <= last_busy; c++) sched[c].busy = 1'b1;
        for (int j = 0; j < NH; j++) begin
            if (mode != 2 || j < 99) begin
                sched[k+1+j].ren   = 1'b1;
                sched[k+1+j].raddr = base + j;
            end
        end
        for (int j = 0; j < nw; j++) begin
            v = sat16(exp_mem[base+j] + dlt[j]);
            sched[k+3+j].wen   = 1'b1;
            sched[k+3+j].waddr = base + j;
            sched[k+3+j].wdata = v;
            exp_mem[base+j]    = v;
        end
        if (mode != 2) begin
            sched[k+257].ren   = 1'b1;
            sched[k+257].raddr = BIAS0 + n;
            v = sat16(exp_mem[BIAS0+n] + b);
            sched[k+259].wen   = 1'b1;
            sched[k+259].waddr = BIAS0 + n;
            sched[k+259].wdata = v;
            sched[k+259].done  = 1'b1;
            exp_mem[BIAS0+n]   = v;
        end

        neuron_idx = 4'(n);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < NH; j++) begin
            delta_weight = 16'(dlt[j]);
            delta_bias   = (j == 0) ? 16'(b) : 16'sh5a5a;
            if (mode == 1 && (j == 4 || j == 199)) begin
                start      = 1'b1;
                neuron_idx = 4'd5;
            end
            if (mode == 2 && j == 99)  reset_b = 1'b0;
            if (mode == 2 && j == 101) reset_b = 1'b1;
            tick();
            start      = 1'b0;
            neuron_idx = 4'(n);
        end
        delta_weight = '0;
        delta_bias   = '0;
    endtask

    initial begin
        int k;
        int k2;
        int w0;
        int d0;

        for (int a = 0; a < 4096; a++) exp_mem[a] = 0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        reset_b = 1'b1;
        repeat (3) tick();

        // Neuron 3, all deltas +2 on a zeroed RAM.
        for (int j = 0; j < NH; j++) dlt[j] = 2;
        w0 = wr_seen;
        run_update(3, 321, 0, k);
        repeat (4) tick();
        check("n3_w768", int'(ram[768]), 2);
        check("n3_w1023", int'(ram[1023]), 2);
        check("n3_bias", int'(ram[2563]), 321);
        check("n3_done_cycle", last_done_cyc - k, 259);
        check("n3_wr_count", wr_seen - w0, 257);
        check_image("n3_image");

        // Saturation at both rails.
        for (int j = 0; j < NH; j++) dlt[j] = 0;
        dlt[0] = 100;
        dlt[1] = -100;
        preload(0, 32760);
        preload(1, -32760);
        commit_load();
        run_update(0, 0, 0, k);
        repeat (4) tick();
        check("sat_pos", int'(ram[0]), 32767);
        check("sat_neg", int'(ram[1]), -32768);
        check_image("sat_image");

        // Ramp deltas on a RAM preloaded with 1000.
        for (int j = 0; j < NH; j++) begin
            dlt[j] = j - 128;
            preload(j, 1000);
        end
        commit_load();
        prev_waddr = -1;
        order_bad  = 0;
        run_update(0, -7, 0, k);
        repeat (4) tick();
        check("ramp_w0", int'(ram[0]), 872);
        check("ramp_w128", int'(ram[128]), 1000);
        check("ramp_w255", int'(ram[255]), 1127);
        check("ramp_bias", int'(ram[2560]), -7);
        check("ramp_order", order_bad, 0);
        check_image("ramp_image");

        // Spurious starts while busy.
        for (int j = 0; j < NH; j++) dlt[j] = (j % 7) - 3;
        d0 = done_seen;
        run_update(2, 50, 1, k);
        repeat (4) tick();
        check("ign_done_pulses", done_seen - d0, 1);
        check("ign_w512", int'(ram[512]), -3);
        check("ign_bias", int'(ram[2562]), 50);
        check_image("ign_image");

        // Reset mid-update, then a clean rerun.
        for (int j = 0; j < NH; j++) dlt[j] = 5;
        run_update(1, 9, 2, k);
        repeat (4) tick();
        check("rst_w96", int'(ram[352]), 5);
        check("rst_w97", int'(ram[353]), 0);
        check("rst_bias", int'(ram[2561]), 0);
        check_image("rst_image");
        run_update(1, 9, 0, k);
        repeat (4) tick();
        check("rerun_w96", int'(ram[352]), 10);
        check("rerun_w97", int'(ram[353]), 5);
        check("rerun_bias", int'(ram[2561]), 9);
        check_image("rerun_image");

        // Back-to-back: neuron 9, then neuron 0 started in the done cycle.
        bias_log.delete();
        for (int j = 0; j < NH; j++) dlt[j] = 3;
        run_update(9, 11, 0, k);
        repeat (2) tick();
        for (int j = 0; j < NH; j++) dlt[j] = -1;
        run_update(0, -13, 0, k2);
        check("b2b_start_gap", k2 - k, 259);
        repeat (4) tick();
        check("b2b_bias_count", bias_log.size(), 2);
        if (bias_log.size() == 2) begin
            check("b2b_bias_addr0", bias_log[0], 2569);
            check("b2b_bias_addr1", bias_log[1], 2560);
        end
        check("b2b_w2304", int'(ram[2304]), 3);
        check("b2b_w2559", int'(ram[2559]), 3);
        check("b2b_bias9", int'(ram[2569]), 11);
        check("b2b_w0", int'(ram[0]), 871);
        check("b2b_bias0", int'(ram[2560]), -20);
        check_image("b2b_image");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
